// File: rtl/egg_round_ctrl.sv
// egg_round_ctrl: round sequencer for an egg-catching game.
// Spawns pseudo-random eggs, times hits and misses, and decides when a game ends.
module egg_round_ctrl #(
  parameter int unsigned ROUND_CYCLES = 50000000,
  parameter int unsigned GAP_CYCLES   = 5000000,
  parameter int unsigned MAX_ROUNDS   = 30,
  parameter int unsigned MAX_MISSES   = 5,
  parameter int unsigned TARGET_SCORE = 19,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [16:0] key,
  input  logic [4:0]  score,
  output logic [16:0] position,
  output logic [1:0]  color,
  output logic        over,
  output logic        busy,
  output logic        hit_pulse,
  output logic        miss_pulse,
  output logic [5:0]  round_cnt,
  output logic [2:0]  miss_cnt
);
  // state | meaning
  // IDLE  | waiting for start, no egg
  // SPAWN | one cycle: advance LFSR, pick egg position and colour
  // SHOW  | egg visible, timer counting down to a miss
  // GAP   | blank between eggs, end-of-game check at terminal count
  // DONE  | game over, counters held until the next start
  typedef enum logic [2:0] {IDLE, SPAWN, SHOW, GAP, DONE} state_t;

  localparam int unsigned MAX_CYC = (ROUND_CYCLES > GAP_CYCLES) ? ROUND_CYCLES : GAP_CYCLES;
  localparam int unsigned TW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TW-1:0] ROUND_LOAD = TW'(ROUND_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);
  localparam logic [5:0]    MAX_ROUNDS_C = 6'(MAX_ROUNDS);
  localparam logic [2:0]    MAX_MISS_C   = 3'(MAX_MISSES);
  localparam logic [4:0]    TARGET_C     = 5'(TARGET_SCORE);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [16:0]   position_q, position_d;
  logic [1:0]    color_q, color_d;
  logic          over_q, over_d;
  logic          busy_q, busy_d;
  logic          hit_pulse_q, hit_pulse_d;
  logic          miss_pulse_q, miss_pulse_d;
  logic [5:0]    round_cnt_q, round_cnt_d;
  logic [2:0]    miss_cnt_q, miss_cnt_d;

  logic [7:0]    lfsr_next;
  logic [7:0]    egg_idx;
  logic [5:0]    round_inc;
  logic [2:0]    miss_inc;
  logic          hit;
  logic          game_end;

  always_comb begin
    lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    egg_idx   = lfsr_next % 8'd17;
    round_inc = (round_cnt_q == 6'h3F) ? round_cnt_q : round_cnt_q + 6'd1;
    miss_inc  = (miss_cnt_q == 3'h7) ? miss_cnt_q : miss_cnt_q + 3'd1;
    hit       = (key == position_q) && (position_q != '0);
    game_end  = (round_cnt_q == MAX_ROUNDS_C) || (miss_cnt_q == MAX_MISS_C) ||
                (score >= TARGET_C);

    state_d      = state_q;
    timer_d      = timer_q;
    lfsr_d       = lfsr_q;
    position_d   = position_q;
    color_d      = color_q;
    over_d       = over_q;
    hit_pulse_d  = 1'b0;
    miss_pulse_d = 1'b0;
    round_cnt_d  = round_cnt_q;
    miss_cnt_d   = miss_cnt_q;

    case (state_q)
      IDLE: begin
        position_d = '0;
        color_d    = '0;
        over_d     = 1'b0;
        if (start) begin
          round_cnt_d = '0;
          miss_cnt_d  = '0;
          state_d     = SPAWN;
        end
      end
      SPAWN: begin
        lfsr_d     = lfsr_next;
        position_d = 17'd1 << egg_idx;
        color_d    = (lfsr_next[1:0] == 2'b00) ? 2'b10 : lfsr_next[1:0];
        timer_d    = ROUND_LOAD;
        state_d    = SHOW;
      end
      SHOW: begin
        // A hit on the terminal-count cycle still counts as a hit.
        if (hit || (timer_q == '0)) begin
          hit_pulse_d  = hit;
          miss_pulse_d = !hit;
          round_cnt_d  = round_inc;
          if (!hit) miss_cnt_d = miss_inc;
          position_d   = '0;
          color_d      = '0;
          timer_d      = GAP_LOAD;
          state_d      = GAP;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      GAP: begin
        position_d = '0;
        color_d    = '0;
        if (timer_q == '0) begin
          if (game_end) begin
            over_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = SPAWN;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      DONE: begin
        position_d = '0;
        color_d    = '0;
        over_d     = 1'b1;
        if (start) begin
          round_cnt_d = '0;
          miss_cnt_d  = '0;
          over_d      = 1'b0;
          state_d     = SPAWN;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) && (state_d != DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      lfsr_q       <= LFSR_SEED;
      position_q   <= '0;
      color_q      <= '0;
      over_q       <= 1'b0;
      busy_q       <= 1'b0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      round_cnt_q  <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      lfsr_q       <= lfsr_d;
      position_q   <= position_d;
      color_q      <= color_d;
      over_q       <= over_d;
      busy_q       <= busy_d;
      hit_pulse_q  <= hit_pulse_d;
      miss_pulse_q <= miss_pulse_d;
      round_cnt_q  <= round_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign position   = position_q;
  assign color      = color_q;
  assign over       = over_q;
  assign busy       = busy_q;
  assign hit_pulse  = hit_pulse_q;
  assign miss_pulse = miss_pulse_q;
  assign round_cnt  = round_cnt_q;
  assign miss_cnt   = miss_cnt_q;
endmodule

// File: tb/tb_egg_round_ctrl.sv
// Bench for egg_round_ctrl: fixed round table, reset corner cases, then random rounds
// checked against a round-level game model.
module tb_egg_round_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [16:0] key;
  logic [4:0]  score;
  logic [16:0] position;
  logic [1:0]  color;
  logic        over, busy, hit_pulse, miss_pulse;
  logic [5:0]  round_cnt;
  logic [2:0]  miss_cnt;

  int errors = 0;
  int checks = 0;
  logic [7:0] lfsr_m;

  typedef struct {
    bit         new_game;
    int         action;    // 0 no key, 1 correct key, 2 wrong key
    int         press_j;   // SHOW cycle during which the key is driven
    logic [4:0] score_v;
    bit         poke;      // pulse start during SHOW
    bit         exp_hit;
    logic [5:0] exp_round;
    logic [2:0] exp_miss;
    bit         exp_over;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  egg_round_ctrl #(
    .ROUND_CYCLES(8), .GAP_CYCLES(2), .MAX_ROUNDS(3), .MAX_MISSES(2),
    .TARGET_SCORE(5), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .score(score),
    .position(position), .color(color), .over(over), .busy(busy),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .round_cnt(round_cnt), .miss_cnt(miss_cnt)
  );

  function automatic logic [7:0] lfsr_adv(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [16:0] egg_pos(input logic [7:0] l);
    logic [16:0] p;
    p = '0;
    p[int'(l) % 17] = 1'b1;
    return p;
  endfunction

  function automatic logic [1:0] egg_col(input logic [7:0] l);
    return (l[1:0] == 2'b00) ? 2'b10 : l[1:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Entered in IDLE or DONE; leaves the DUT sampled in SPAWN.
  task automatic start_game(input bit in_done, input logic [5:0] r, input logic [2:0] m);
    repeat (2) begin
      step();
      chk("idle_over", over, in_done);
      chk("idle_busy", busy, 0);
      chk("idle_position", position, 0);
      chk("idle_round_cnt", round_cnt, r);
      chk("idle_miss_cnt", miss_cnt, m);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_over", over, 0);
    chk("start_round_cnt", round_cnt, 0);
    chk("start_miss_cnt", miss_cnt, 0);
    chk("spawn_position", position, 0);
  endtask

  // Entered sampled in SPAWN; leaves the DUT sampled in SPAWN or DONE.
  task automatic run_round(input int action, input int press_j, input logic [4:0] score_v,
                           input bit poke, input bit exp_hit, input logic [5:0] exp_round,
                           input logic [2:0] exp_miss, input bit exp_over);
    logic [16:0] exp_pos, wrong;
    logic [1:0]  exp_col;
    int vis;
    bit ended;
    lfsr_m  = lfsr_adv(lfsr_m);
    exp_pos = egg_pos(lfsr_m);
    exp_col = egg_col(lfsr_m);
    wrong   = {exp_pos[15:0], exp_pos[16]};
    step();
    chk("egg_position", position, exp_pos);
    chk("egg_color", color, exp_col);
    vis   = (position == exp_pos) ? 1 : 0;
    ended = 1'b0;
    for (int j = 1; j <= 12 && !ended; j++) begin
      if (action != 0 && j >= press_j) key = (action == 1) ? exp_pos : wrong;
      if (poke && j == 2) start = 1'b1;
      step();
      start = 1'b0;
      if (hit_pulse || miss_pulse) ended = 1'b1;
      else if (position == exp_pos) vis++;
    end
    chk("round_end_seen", ended, 1);
    chk("visible_cycles", vis, exp_hit ? press_j : 8);
    chk("hit_pulse", hit_pulse, exp_hit);
    chk("miss_pulse", miss_pulse, !exp_hit);
    chk("gap_position", position, 0);
    chk("round_cnt", round_cnt, exp_round);
    chk("miss_cnt", miss_cnt, exp_miss);
    score = score_v;
    step();
    chk("pulse_one_cycle", {hit_pulse, miss_pulse}, 0);
    chk("gap_pos_color", {position, color}, 0);
    chk("busy_in_gap", busy, 1);
    step();
    chk("over", over, exp_over);
    chk("busy_after_gap", busy, !exp_over);
    chk("position_after_gap", position, 0);
    chk("held_round_cnt", round_cnt, exp_round);
    chk("held_miss_cnt", miss_cnt, exp_miss);
    key   = '0;
    score = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit m_over;
    logic [5:0] m_round;
    logic [2:0] m_miss;
    logic [5:0] p_round;
    logic [2:0] p_miss;
    bit p_over;
    int action, press_j;
    logic [4:0] score_v;
    bit poke, hit;

    //               new act pj score  poke hit round miss over
    vecs[0]  = '{1'b1, 0, 1, 5'd0,  1'b0, 1'b0, 6'd1, 3'd1, 1'b0};
    vecs[1]  = '{1'b0, 0, 1, 5'd0,  1'b0, 1'b0, 6'd2, 3'd2, 1'b1};
    vecs[2]  = '{1'b1, 1, 3, 5'd0,  1'b0, 1'b1, 6'd1, 3'd0, 1'b0};
    vecs[3]  = '{1'b0, 1, 8, 5'd0,  1'b0, 1'b1, 6'd2, 3'd0, 1'b0};
    vecs[4]  = '{1'b0, 2, 2, 5'd0,  1'b1, 1'b0, 6'd3, 3'd1, 1'b1};
    vecs[5]  = '{1'b1, 0, 1, 5'd5,  1'b0, 1'b0, 6'd1, 3'd1, 1'b1};
    vecs[6]  = '{1'b1, 1, 1, 5'd4,  1'b0, 1'b1, 6'd1, 3'd0, 1'b0};
    vecs[7]  = '{1'b0, 2, 5, 5'd31, 1'b0, 1'b0, 6'd2, 3'd1, 1'b1};
    vecs[8]  = '{1'b1, 1, 6, 5'd0,  1'b0, 1'b1, 6'd1, 3'd0, 1'b0};
    vecs[9]  = '{1'b0, 1, 2, 5'd0,  1'b0, 1'b1, 6'd2, 3'd0, 1'b0};
    vecs[10] = '{1'b0, 1, 7, 5'd0,  1'b1, 1'b1, 6'd3, 3'd0, 1'b1};

    rst = 1'b0; start = 1'b0; key = '0; score = '0;
    lfsr_m = 8'hA5;
    step();
    chk("rst_position", position, 0);
    chk("rst_color", color, 0);
    chk("rst_over", over, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {hit_pulse, miss_pulse}, 0);
    chk("rst_round_cnt", round_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    rst = 1'b1;

    p_over = 1'b0; p_round = '0; p_miss = '0;
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].new_game) start_game(p_over, p_round, p_miss);
      run_round(vecs[i].action, vecs[i].press_j, vecs[i].score_v, vecs[i].poke,
                vecs[i].exp_hit, vecs[i].exp_round, vecs[i].exp_miss, vecs[i].exp_over);
      p_over  = vecs[i].exp_over;
      p_round = vecs[i].exp_round;
      p_miss  = vecs[i].exp_miss;
    end

    // Reset mid-SHOW: egg vanishes at once, no pulse, first egg replays.
    rst = 1'b0;
    step();
    rst = 1'b1;
    lfsr_m = 8'hA5;
    start_game(1'b0, 6'd0, 3'd0);
    step();
    chk("first_egg", position, egg_pos(lfsr_adv(8'hA5)));
    step();
    step();
    #2 rst = 1'b0;
    #1;
    chk("async_position", position, 0);
    chk("async_busy", busy, 0);
    chk("async_pulses", {hit_pulse, miss_pulse}, 0);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("post_rst_pulses", {hit_pulse, miss_pulse}, 0);
    chk("post_rst_position", position, 0);
    lfsr_m = 8'hA5;
    start_game(1'b0, 6'd0, 3'd0);
    run_round(1, 2, 5'd0, 1'b0, 1'b1, 6'd1, 3'd0, 1'b0);

    m_over = 1'b0; m_round = 6'd1; m_miss = 3'd0;
    for (int r = 0; r < 40; r++) begin
      if (m_over) begin
        start_game(1'b1, m_round, m_miss);
        m_round = '0;
        m_miss  = '0;
      end
      action  = int'($urandom_range(0, 2));
      press_j = int'($urandom_range(1, 8));
      score_v = 5'($urandom_range(0, 6));
      poke    = 1'($urandom_range(0, 1));
      hit     = (action == 1);
      m_round = m_round + 6'd1;
      if (!hit) m_miss = m_miss + 3'd1;
      m_over  = (m_round == 6'd3) || (m_miss == 3'd2) || (score_v >= 5'd5);
      run_round(action, press_j, score_v, poke, hit, m_round, m_miss, m_over);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/egg_round_ctrl.md
EGG_ROUND_CTRL -- requirements
Module: egg_round_ctrl

Interface
REQ-001 The parameters SHALL be as follows (name, default, meaning):
- ROUND_CYCLES, 50000000: cycles an egg stays visible.
- GAP_CYCLES, 5000000: blank cycles between eggs.
- MAX_ROUNDS, 30: eggs per game.
- MAX_MISSES, 5: misses that end the game.
- TARGET_SCORE, 19: score that ends the game.
- LFSR_SEED, 8'hA5: nonzero LFSR reset value.

REQ-002 The ports SHALL be as follows (name, direction, width, meaning):
- clk, in, 1: the only clock.
- rst, in, 1: asynchronous active-low reset.
- start, in, 1: starts a game; sampled in IDLE and DONE only.
- key, in, 17: one-hot player key vector.
- score, in, 5: running score from the scoring block.
- position, out, 17: one-hot egg position, or 0 for no egg.
- color, out, 2: egg colour; never 2'b00 while position != 0.
- over, out, 1: game finished.
- busy, out, 1: high in any state other than IDLE and DONE.
- hit_pulse, out, 1: one-cycle pulse on a hit.
- miss_pulse, out, 1: one-cycle pulse on a timeout.
- round_cnt, out, 6: eggs completed this game.
- miss_cnt, out, 3: misses this game.

REQ-003 The block SHALL have one clock, clk; reset SHALL be asynchronous and active-low on port rst.
REQ-004 All outputs SHALL be registered.

Function
REQ-005 The FSM states SHALL be IDLE, SPAWN, SHOW, GAP and DONE.
REQ-006 IDLE: position=0, color=0, over=0; on start=1 the block SHALL clear round_cnt and miss_cnt and go to SPAWN.
REQ-007 SPAWN, which lasts 1 cycle, SHALL:
- advance the 8-bit Fibonacci LFSR: shift left, feedback = l[7]^l[5]^l[4]^l[3];
- set idx = new_lfsr mod 17 and position = 1<<idx;
- set color = new_lfsr[1:0], with 2'b00 replaced by 2'b10;
- load timer = ROUND_CYCLES-1 and go to SHOW.
REQ-008 SHOW SHALL hold position and color; a hit is key==position with position!=0.
REQ-009 On a hit in SHOW, the block SHALL pulse hit_pulse, increment round_cnt, and enter GAP with position=0 on the next cycle, so the scorer sees exactly one matching cycle.
REQ-010 When the timer reaches 0 in SHOW with no hit, the block SHALL pulse miss_pulse, increment round_cnt and miss_cnt, and enter GAP.
REQ-011 When a hit and timer==0 occur in the same cycle, the hit SHALL win, with no miss counted.
REQ-012 A key that is nonzero but does not match position SHALL have no effect; the timer SHALL keep running.
REQ-013 GAP SHALL drive position=0 and color=0 for GAP_CYCLES cycles.
REQ-014 At the end of GAP, the block SHALL go to DONE if round_cnt==MAX_ROUNDS, or miss_cnt==MAX_MISSES, or score>=TARGET_SCORE; otherwise it SHALL go to SPAWN.
REQ-015 The end-of-game checks SHALL be evaluated only at the end of GAP, never mid-SHOW.
REQ-016 DONE: over=1, position=0, color=0; round_cnt and miss_cnt SHALL hold.
REQ-017 In DONE, start=1 SHALL clear the counters, drop over on the next cycle, and go to SPAWN.
REQ-018 start SHALL be ignored while busy=1.
REQ-019 round_cnt and miss_cnt SHALL saturate at their maximum values and never wrap.
REQ-020 The timer SHALL be ceil(log2(max(ROUND_CYCLES,GAP_CYCLES))) bits wide and SHALL be shared between SHOW and GAP.
REQ-021 The LFSR SHALL never reach 0.
REQ-022 The LFSR SHALL advance only in SPAWN.
REQ-023 hit_pulse and miss_pulse SHALL each be high for exactly 1 cycle per event and SHALL never be high together.

Reset
REQ-024 On rst=0, immediately and independent of clk, the block SHALL set:
- state=IDLE;
- position=0, color=0, over=0, busy=0;
- hit_pulse=0, miss_pulse=0;
- round_cnt=0, miss_cnt=0;
- timer=0, lfsr=LFSR_SEED.
REQ-025 Reset asserted mid-SHOW SHALL clear position in the same cycle, and no pulse SHALL be emitted.
REQ-026 After rst returns to 1, the block SHALL stay in IDLE until start.

Verification
All scenarios use ROUND_CYCLES=8, GAP_CYCLES=2, MAX_ROUNDS=3, MAX_MISSES=2, TARGET_SCORE=5.
REQ-027 Reset then start with key=0 held:
- each egg is visible 8 cycles, then miss_pulse fires and position=0 for 2 cycles;
- after 2 eggs miss_cnt=2 and over=1, with round_cnt=2.
REQ-028 Press key=position on the 3rd SHOW cycle:
- hit_pulse fires that cycle, position=0 on the next cycle, round_cnt=1, miss_cnt=0;
- the key vector is held so the scorer matches for 1 cycle only.
REQ-029 Hit on the same cycle the timer reaches 0: hit_pulse=1, miss_pulse=0, miss_cnt unchanged.
REQ-030 Force score=5 during the 1st GAP: DONE at the end of the GAP with round_cnt=1; start in DONE clears over and counters and spawns a new egg.
REQ-031 A wrong one-hot key during SHOW produces no pulse, and the egg times out after the full 8 cycles; start pulsed in SHOW is ignored.
REQ-032 Drop rst mid-SHOW: position=0 asynchronously, LFSR back to 8'hA5, and the first egg after restart is identical to the first egg after power-on.
